// File: rtl/data_mem_hs.sv
// Word-organised data memory with a valid/ready request/response handshake and
// byte/halfword/word loads and stores. One request in flight; fixed LATENCY.
module data_mem_hs #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request transfers on a rising edge where req_valid & req_ready;
    // a response transfers on a rising edge where resp_valid & resp_ready.
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_we, lat_uns;
    logic [1:0]  lat_size;

    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    logic          accept, commit;
    logic [31:0]   cur_addr, cur_wdata;
    logic          cur_we, cur_uns;
    logic [1:0]    cur_size;
    logic [AW-1:0] idx;
    logic          fault;
    logic [3:0]    be;
    logic [31:0]   wbytes, word_rd, shifted, load_data;
    logic [15:0]   half_sel;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; cnt counts the BUSY cycles still to go
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : BUSY;
            BUSY: if (cnt <= 4'd1) state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        dbg_state  = state;
    end

    assign accept = req_valid && req_ready;
    assign commit = (state_nxt == RESP) && (state != RESP) && !reset;

    // With LATENCY = 1 the commit edge is the accept edge, so use the live inputs
    always_comb begin
        cur_addr  = (state == IDLE) ? req_addr     : lat_addr;
        cur_wdata = (state == IDLE) ? req_wdata    : lat_wdata;
        cur_we    = (state == IDLE) ? req_we       : lat_we;
        cur_size  = (state == IDLE) ? req_size     : lat_size;
        cur_uns   = (state == IDLE) ? req_unsigned : lat_uns;
    end

    always_comb begin
        idx   = cur_addr[AW+1:2];
        fault = (cur_size == 2'b11) ||
                (cur_size == 2'b01 && cur_addr[0]) ||
                (cur_size == 2'b10 && cur_addr[1:0] != 2'b00) ||
                (cur_addr[31:AW+2] != '0);
        case (cur_size)
            2'b00:   begin be = 4'b0001 << cur_addr[1:0];               wbytes = {4{cur_wdata[7:0]}};  end
            2'b01:   begin be = cur_addr[1] ? 4'b1100 : 4'b0011;        wbytes = {2{cur_wdata[15:0]}}; end
            default: begin be = 4'b1111;                                wbytes = cur_wdata;            end
        endcase
        word_rd  = mem[idx];
        shifted  = word_rd >> {cur_addr[1:0], 3'b000};
        half_sel = cur_addr[1] ? word_rd[31:16] : word_rd[15:0];
        load_data = '0;
        if (!fault && !cur_we) begin
            case (cur_size)
                2'b00:   load_data = cur_uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                2'b01:   load_data = cur_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
                default: load_data = word_rd;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_we    <= req_we;
                lat_size  <= req_size;
                lat_uns   <= req_unsigned;
                cnt       <= LAT_M1;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                resp_rdata <= load_data;
                resp_err   <= fault;
            end
        end
    end

    // Memory contents survive reset; only committed, non-faulting stores write
    always_ff @(posedge clk) begin
        if (commit && cur_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wbytes[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_hs.sv
// Self-checking bench for data_mem_hs: vector table, scoreboard queue and
// hand-written handshake/reset sequences on a LATENCY=2 and a LATENCY=3 instance.
module tb_data_mem_hs;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  dbg_state;

    logic        r3_valid, r3_ready, r3_we, r3_uns;
    logic [31:0] r3_addr, r3_wdata;
    logic [1:0]  r3_size;
    logic        r3_rvalid, r3_rready, r3_err;
    logic [31:0] r3_rdata;
    logic [1:0]  r3_dbg;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;
    vec_t vecs[$];

    data_mem_hs #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
    );

    data_mem_hs #(.DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(r3_valid), .req_ready(r3_ready), .req_addr(r3_addr),
        .req_wdata(r3_wdata), .req_we(r3_we), .req_size(r3_size),
        .req_unsigned(r3_uns),
        .resp_valid(r3_rvalid), .resp_ready(r3_rready),
        .resp_rdata(r3_rdata), .resp_err(r3_err), .dbg_state(r3_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input string name);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
        vecs.push_back(v);
    endtask

    // Driver: one request on dut with resp_ready high; checks latency and response
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input string name);
        logic        ready_now;
        logic [32:0] exp;
        int          n;
        exp_q.push_back({exp_err, exp_rdata});
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        n = 0;
        ready_now = 1'b0;
        while (n < 50) begin
            ready_now = req_ready;
            tick();
            n++;
            if (ready_now) break;
        end
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        req_addr  = 32'hFFFF_FFFF;
        if (!ready_now) check({name, " accept timeout"}, 0, 1);
        n = 0;
        while (!resp_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, " latency"}, 64'(n + 1), 64'(LAT));
        exp = exp_q.pop_front();
        check(name, {31'd0, resp_valid, resp_err, resp_rdata}, {31'd0, 1'b1, exp});
        tick();
    endtask

    logic [31:0] model_mem [64];
    int          used_k[$];

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        r3_valid = 1'b0; r3_we = 1'b0; r3_size = 2'b10; r3_uns = 1'b0;
        r3_addr = '0; r3_wdata = '0; r3_rready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("reset outputs", {60'd0, req_ready, resp_valid, resp_err, |resp_rdata},
              {60'd0, 4'b1000});

        // Table: we size uns addr wdata exp_rdata exp_err
        add_vec(1, 2'b10, 0, 32'h10,   32'h8000_1234, 32'h0,         0, "sw 0x10");
        add_vec(0, 2'b10, 0, 32'h10,   32'h0,         32'h8000_1234, 0, "lw 0x10");
        add_vec(1, 2'b00, 0, 32'h21,   32'h0000_00AB, 32'h0,         0, "sb 0x21");
        add_vec(0, 2'b00, 0, 32'h21,   32'h0,         32'hFFFF_FFAB, 0, "lb 0x21");
        add_vec(0, 2'b00, 1, 32'h21,   32'h0,         32'h0000_00AB, 0, "lbu 0x21");
        add_vec(0, 2'b10, 0, 32'h20,   32'h0,         32'h0000_AB00, 0, "lw 0x20");
        add_vec(1, 2'b01, 0, 32'h32,   32'h0000_8001, 32'h0,         0, "sh 0x32");
        add_vec(0, 2'b01, 0, 32'h32,   32'h0,         32'hFFFF_8001, 0, "lh 0x32");
        add_vec(0, 2'b01, 1, 32'h30,   32'h0,         32'h0,         0, "lhu 0x30");
        add_vec(0, 2'b01, 0, 32'h31,   32'h0,         32'h0,         1, "lh 0x31 misaligned");
        add_vec(0, 2'b00, 1, 32'h33,   32'h0,         32'h0000_0080, 0, "lbu 0x33");
        add_vec(1, 2'b10, 0, 32'h1002, 32'hDEAD_BEEF, 32'h0,         1, "sw 0x1002 misaligned");
        add_vec(1, 2'b10, 0, 32'h1000, 32'h1111_1111, 32'h0,         1, "sw 0x1000 out of range");
        add_vec(1, 2'b00, 0, 32'h1001, 32'h0000_0055, 32'h0,         1, "sb 0x1001 out of range");
        add_vec(0, 2'b10, 0, 32'h0,    32'h0,         32'h0,         0, "lw 0x0 untouched");
        add_vec(0, 2'b10, 0, 32'h2,    32'h0,         32'h0,         1, "lw 0x2 misaligned");
        add_vec(0, 2'b11, 0, 32'h10,   32'h0,         32'h0,         1, "load size 11");
        add_vec(1, 2'b11, 0, 32'h44,   32'hFFFF_FFFF, 32'h0,         1, "store size 11");
        add_vec(0, 2'b10, 0, 32'h44,   32'h0,         32'h0,         0, "lw 0x44 untouched");
        add_vec(1, 2'b00, 0, 32'h13,   32'hFFFF_FF7F, 32'h0,         0, "sb 0x13");
        add_vec(0, 2'b00, 0, 32'h13,   32'h0,         32'h0000_007F, 0, "lb 0x13");
        add_vec(0, 2'b10, 1, 32'h10,   32'h0,         32'h7F00_1234, 0, "lw 0x10 after sb");
        add_vec(1, 2'b01, 0, 32'h10,   32'h1234_CAFE, 32'h0,         0, "sh 0x10");
        add_vec(0, 2'b01, 0, 32'h10,   32'h0,         32'hFFFF_CAFE, 0, "lh 0x10");
        add_vec(0, 2'b01, 0, 32'h12,   32'h0,         32'h0000_7F00, 0, "lh 0x12");
        add_vec(0, 2'b01, 1, 32'h10,   32'h0,         32'h0000_CAFE, 0, "lhu 0x10");
        add_vec(1, 2'b10, 0, 32'hFFC,  32'hA5A5_A5A5, 32'h0,         0, "sw top word");
        add_vec(0, 2'b10, 0, 32'hFFC,  32'h0,         32'hA5A5_A5A5, 0, "lw top word");
        add_vec(0, 2'b00, 0, 32'hFFF,  32'h0,         32'hFFFF_FFA5, 0, "lb top byte");
        add_vec(0, 2'b10, 0, 32'h8000_0000, 32'h0,    32'h0,         1, "lw high addr bit");
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name);
        end

        // Random word stores/loads against a reference array
        for (int k = 0; k < 64; k++) model_mem[k] = '0;
        for (int i = 0; i < 10; i++) begin
            int          k;
            logic [31:0] d;
            k = $urandom_range(0, 63);
            d = $urandom;
            model_mem[k] = d;
            used_k.push_back(k);
            issue(1, 2'b10, 0, 32'h100 + 32'(4 * k), d, 32'h0, 0, "rand sw");
        end
        foreach (used_k[i]) begin
            issue(0, 2'b10, 0, 32'h100 + 32'(4 * used_k[i]), 32'h0,
                  model_mem[used_k[i]], 0, "rand lw");
        end

        // Backpressure: resp_ready low 5 cycles while req_valid stays high
        issue(1, 2'b10, 0, 32'h80, 32'h1357_9BDF, 32'h0, 0, "sw 0x80");
        begin
            int n;
            resp_ready = 1'b0;
            req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
            req_addr = 32'h80; req_wdata = '0;
            exp_q.push_back({1'b0, 32'h1357_9BDF});
            tick();
            n = 0;
            while (!resp_valid && n < 50) begin
                tick();
                n++;
            end
            for (int c = 0; c < 5; c++) begin
                check("backpressure hold", {29'd0, resp_valid, req_ready, resp_err, resp_rdata},
                      {29'd0, 1'b1, 1'b0, exp_q[0]});
                tick();
            end
            check("backpressure final", {31'd0, resp_err, resp_rdata}, {31'd0, exp_q.pop_front()});
            resp_ready = 1'b1;
            tick();
            check("ready after handshake", {62'd0, req_ready, resp_valid}, {62'd0, 2'b10});
            exp_q.push_back({1'b0, 32'h1357_9BDF});
            tick();
            check("held req accepted", {63'd0, req_ready}, 64'd0);
            req_valid = 1'b0;
            n = 0;
            while (!resp_valid && n < 50) begin
                tick();
                n++;
            end
            check("second resp", {31'd0, resp_valid, resp_err, resp_rdata},
                  {31'd0, 1'b1, exp_q.pop_front()});
            tick();
        end

        // Reset while in RESP: valid drops, committed store stays
        begin
            int n;
            resp_ready = 1'b0;
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h50;
            req_wdata = 32'h0000_0077;
            tick();
            req_valid = 1'b0;
            n = 0;
            while (!resp_valid && n < 50) begin
                tick();
                n++;
            end
            check("resp before reset", {63'd0, resp_valid}, 64'd1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            resp_ready = 1'b1;
            check("reset in RESP", {29'd0, resp_valid, resp_err, req_ready, resp_rdata},
                  {29'd0, 3'b001, 32'h0});
            issue(0, 2'b10, 0, 32'h50, 32'h0, 32'h0000_0077, 0, "lw 0x50 after reset");
        end

        // Reset has priority over an accept in the same cycle
        begin
            logic seen;
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h60;
            req_wdata = 32'hFFFF_FFFF;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            req_valid = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 5; c++) begin
                if (resp_valid || !req_ready) seen = 1'b1;
                tick();
            end
            check("reset beats accept", {63'd0, seen}, 64'd0);
            issue(0, 2'b10, 0, 32'h60, 32'h0, 32'h0, 0, "lw 0x60 not written");
        end

        // LATENCY=3 instance: reset one cycle after accept aborts the store
        begin
            logic seen;
            int   n;
            r3_valid = 1'b1; r3_we = 1'b1; r3_size = 2'b10; r3_addr = 32'h40;
            r3_wdata = 32'h0000_0005;
            check("lat3 ready", {63'd0, r3_ready}, 64'd1);
            tick();
            r3_valid = 1'b0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 6; c++) begin
                if (r3_rvalid) seen = 1'b1;
                tick();
            end
            check("lat3 aborted no resp", {63'd0, seen}, 64'd0);
            r3_valid = 1'b1; r3_we = 1'b0; r3_addr = 32'h40;
            exp_q.push_back({1'b0, 32'h0});
            tick();
            r3_valid = 1'b0;
            n = 0;
            while (!r3_rvalid && n < 50) begin
                tick();
                n++;
            end
            check("lat3 latency", 64'(n + 1), 64'd3);
            check("lat3 lw 0x40", {31'd0, r3_rvalid, r3_err, r3_rdata},
                  {31'd0, 1'b1, exp_q.pop_front()});
            tick();
        end

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_hs.md
DATA_MEM_HS -- requirements
Module: data_mem_hs

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to response valid (1..15).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port req_we  input  1  1 store, 0 load.
REQ-010 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-011 SHALL have port req_unsigned  input  1  1 zero-extend, 0 sign-extend loads.
REQ-012 SHALL have port resp_valid  output  1  response present.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-014 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  request faulted (misaligned, illegal size, out of range).

Function
REQ-016 SHALL implement FSM IDLE, BUSY, RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-017 Accept SHALL occur on a cycle with req_valid & req_ready; all req_* fields latched at that edge; later input changes ignored.
REQ-018 IDLE -> BUSY on accept with wait counter loaded to LATENCY-1; if LATENCY = 1, IDLE -> RESP directly.
REQ-019 BUSY SHALL decrement counter each cycle and move to RESP on the edge where counter is 0; resp_valid first high exactly LATENCY cycles after the accept edge.
REQ-020 RESP SHALL hold resp_valid, resp_rdata, resp_err stable until resp_valid & resp_ready; then -> IDLE; req_ready high the following cycle (no back-to-back accept).
REQ-021 Word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0].
REQ-022 Fault SHALL be flagged if size = 11, halfword with addr[0] = 1, word with addr[1:0] != 00, or any addr bit above the index field nonzero.
REQ-023 Faulted request SHALL not modify memory; resp_err = 1, resp_rdata = 0.
REQ-024 Store SHALL commit on the BUSY/IDLE -> RESP edge, writing only the addressed lanes: byte lane n gets wdata[7:0]; halfword lanes 1:0 or 3:2 get wdata[15:0]; word writes all 32 bits.
REQ-025 Load SHALL sample memory on the same -> RESP edge and register result: selected byte/half sign- or zero-extended per latched req_unsigned; word returned unchanged; req_unsigned ignored for words.
REQ-026 Store response SHALL have resp_rdata = 0, resp_err = 0.
REQ-027 A load following a store to same word SHALL observe the stored data (store committed before load accepted).
REQ-028 Memory array SHALL be zero at simulation start; reset SHALL not clear memory contents.

Reset
REQ-029 reset high at a rising edge SHALL force IDLE, counter 0, req_ready = 1 from next cycle, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-030 reset in BUSY SHALL abort the request: pending store never committed, no response produced.
REQ-031 reset in RESP SHALL drop resp_valid without requiring resp_ready; committed store remains.
REQ-032 reset SHALL take priority over accept and over response handshake in the same cycle.

Verification
REQ-033 LATENCY=2: sw 0x8000_1234 @0x10 accepted cycle N -> resp_valid at N+2, err 0; lw @0x10 -> 0x80001234.
REQ-034 sb 0xAB @0x21, then lb @0x21 -> 0xFFFFFFAB, lbu @0x21 -> 0x000000AB, lw @0x20 -> 0x0000AB00.
REQ-035 sh 0x8001 @0x32, lh @0x32 -> 0xFFFF8001, lhu @0x30 -> 0x00000000; lh @0x31 -> err 1, rdata 0.
REQ-036 sw @0x1002 (misaligned) and sw @0x1000 with DEPTH_WORDS=1024 (out of range) -> err 1, later lw @0x0 and @0x1000-free addresses unchanged.
REQ-037 resp_ready held low 5 cycles -> resp_valid and data stable, req_ready 0 throughout; req_valid held high accepted only cycle after handshake.
REQ-038 sw 0x5 @0x40 then reset asserted one cycle after accept (LATENCY=3) -> no resp_valid; subsequent lw @0x40 -> 0x00000000.
